change_dispenser: RTL and testbench

//   Pays out change owed by the vending FSM. Takes a change request in 5-unit

---
 rtl/change_dispenser.sv | 204 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change payout controller driving a two-tube (nickel/dime) coin hopper with greedy coin selection.
// Optional hopper-ack timeout enabled by defining CHANGE_DISP_TIMEOUT_EN.
module change_dispenser #(
   parameter int AMT_W      = 4,
   parameter int INV_W      = 8,
   parameter int INIT_NCK   = 20,
   parameter int INIT_DIM   = 10,
   parameter int REFILL_QTY = 10,
   parameter int ACK_TMO    = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amt,
   output logic             req_ready,
   output logic             hop_fire,
   output logic             hop_sel,
   input  logic             hop_ack,
   input  logic             refill_nck,
   input  logic             refill_dim,
   output logic             done,
   output logic [AMT_W-1:0] short_amt,
   output logic             fault,
   output logic [INV_W-1:0] nck_cnt,
   output logic [INV_W-1:0] dim_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      FIRE,
      WAIT_ACK,
      DONE,
      FAULT
   } state_t;

   localparam logic [INV_W-1:0] INIT_N     = INV_W'(INIT_NCK);
   localparam logic [INV_W-1:0] INIT_D     = INV_W'(INIT_DIM);
   localparam logic [INV_W+1:0] REFILL_EXT = (INV_W + 2)'(REFILL_QTY);
   localparam logic [INV_W+1:0] CNT_MAX    = {2'b00, {INV_W{1'b1}}};

   state_t           state;
   state_t           state_nxt;
   logic [AMT_W-1:0] rem;
   logic             take_req;
   logic             ack_take;
   logic             pick_dim;
   logic             pick_nck;
   logic             timeout_hit;
   logic             nck_dec;
   logic             dim_dec;

   assign take_req = req_valid && (state == IDLE);
   assign ack_take = hop_ack && (state == WAIT_ACK);
   assign pick_dim = (rem >= AMT_W'(2)) && (dim_cnt != '0);
   assign pick_nck = !pick_dim && (rem != '0) && (nck_cnt != '0);
   assign nck_dec  = ack_take && !hop_sel;
   assign dim_dec  = ack_take && hop_sel;

`ifdef CHANGE_DISP_TIMEOUT_EN
   localparam int TMO_W = $clog2(ACK_TMO + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Counts WAIT_ACK cycles; restarts every time a new coin is awaited.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state != WAIT_ACK) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == WAIT_ACK) && (tmo_cnt == TMO_W'(ACK_TMO - 1));
`else
   logic unused_tmo;

   assign unused_tmo  = ACK_TMO[0];
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (take_req) begin
               state_nxt = SELECT;
            end
         end
         SELECT: begin
            if (pick_dim || pick_nck) begin
               state_nxt = FIRE;
            end else begin
               state_nxt = DONE;
            end
         end
         FIRE: begin
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (hop_ack) begin
               state_nxt = SELECT;
            end else if (timeout_hit) begin
               state_nxt = FAULT;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         FAULT: begin
            state_nxt = FAULT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      hop_fire  = 1'b0;
      done      = 1'b0;
      fault     = 1'b0;
      case (state)
         IDLE:     req_ready = 1'b1;
         FIRE:     hop_fire  = 1'b1;
         DONE:     done      = 1'b1;
`ifdef CHANGE_DISP_TIMEOUT_EN
         FAULT:    fault     = 1'b1;
`endif
         default: begin
         end
      endcase
   end

   // Remaining amount owed; a dime is only ever chosen when rem >= 2, so no underflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
      end else if (take_req) begin
         rem <= req_amt;
      end else if (ack_take) begin
         rem <= rem - (hop_sel ? AMT_W'(2) : AMT_W'(1));
      end
   end

   // Tube select is chosen in SELECT and held until the coin is acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hop_sel <= 1'b0;
      end else if (state == SELECT) begin
         if (pick_dim) begin
            hop_sel <= 1'b1;
         end else if (pick_nck) begin
            hop_sel <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         short_amt <= '0;
      end else if (take_req) begin
         short_amt <= '0;
      end else if ((state == SELECT) && !pick_dim && !pick_nck) begin
         short_amt <= rem;
      end else if (timeout_hit && !hop_ack) begin
         short_amt <= rem;
      end
   end

   // Refill and coin removal can land together; both apply with saturation at the top.
   function automatic logic [INV_W-1:0] next_cnt(input logic [INV_W-1:0] cnt,
                                                  input logic             add,
                                                  input logic             dec);
      logic [INV_W+1:0] sum;
      sum = {2'b00, cnt} + (add ? REFILL_EXT : '0) - (dec ? (INV_W + 2)'(1) : '0);
      if (sum > CNT_MAX) begin
         return {INV_W{1'b1}};
      end
      return sum[INV_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nck_cnt <= INIT_N;
         dim_cnt <= INIT_D;
      end else begin
         nck_cnt <= next_cnt(nck_cnt, refill_nck, nck_dec);
         dim_cnt <= next_cnt(dim_cnt, refill_dim, dim_dec);
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: per-cycle greedy payout model plus literal spot checks.
// Timeout checks are compiled in when CHANGE_DISP_TIMEOUT_EN is defined.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic [3:0] req_amt;
   logic       req_ready;
   logic       hop_fire;
   logic       hop_sel;
   logic       hop_ack;
   logic       refill_nck;
   logic       refill_dim;
   logic       done;
   logic [3:0] short_amt;
   logic       fault;
   logic [7:0] nck_cnt;
   logic [7:0] dim_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Transaction-level model of the dispenser.
   int m_nck, m_dim, m_rem, m_short;
   bit m_busy, m_out, m_sel;
   bit chk_en = 1'b0;

   bit fired[$];
   int lat;

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_amt    (req_amt),
      .req_ready  (req_ready),
      .hop_fire   (hop_fire),
      .hop_sel    (hop_sel),
      .hop_ack    (hop_ack),
      .refill_nck (refill_nck),
      .refill_dim (refill_dim),
      .done       (done),
      .short_amt  (short_amt),
      .fault      (fault),
      .nck_cnt    (nck_cnt),
      .dim_cnt    (dim_cnt)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s: got no response, want response within bound", name);
   endtask

   function automatic bit can_pay(input int rem, input int nck, input int dim);
      return ((rem >= 2) && (dim > 0)) || ((rem >= 1) && (nck > 0));
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic modelReset();
      m_nck   = 20;
      m_dim   = 10;
      m_rem   = 0;
      m_short = 0;
      m_busy  = 1'b0;
      m_out   = 1'b0;
      m_sel   = 1'b0;
   endtask

   // Model state advances on the same edges the inputs are sampled.
   always @(posedge clk) begin
      if (rst_n && chk_en) begin
         int dn, dd;
         dn = (hop_ack && m_out && !m_sel) ? 1 : 0;
         dd = (hop_ack && m_out && m_sel) ? 1 : 0;
         if (hop_ack && m_out) begin
            m_rem = m_rem - (m_sel ? 2 : 1);
            m_out = 1'b0;
         end
         m_nck = sat(m_nck + (refill_nck ? 10 : 0) - dn);
         m_dim = sat(m_dim + (refill_dim ? 10 : 0) - dd);
         if (req_valid && !m_busy) begin
            m_busy  = 1'b1;
            m_rem   = int'(req_amt);
            m_short = 0;
         end
      end
   end

   // Compare process: DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         checkOutput("req_ready", int'(req_ready), int'(!m_busy));
         if (hop_fire) begin
            bit want_dime;
            checkOutput("fire_legal", int'(m_busy && !m_out && can_pay(m_rem, m_nck, m_dim)), 1);
            want_dime = (m_rem >= 2) && (m_dim > 0);
            checkOutput("hop_sel", int'(hop_sel), int'(want_dime));
            m_out = 1'b1;
            m_sel = want_dime;
         end else if (m_out) begin
            checkOutput("hop_sel_hold", int'(hop_sel), int'(m_sel));
         end
         if (done) begin
            checkOutput("done_legal", int'(m_busy && !m_out && !can_pay(m_rem, m_nck, m_dim)), 1);
            m_short = m_rem;
            m_busy  = 1'b0;
         end
         checkOutput("short_amt", int'(short_amt), m_short);
         checkOutput("fault", int'(fault), 0);
         checkOutput("nck_cnt", int'(nck_cnt), m_nck);
         checkOutput("dim_cnt", int'(dim_cnt), m_dim);
      end
   end

   // Issues one request and acknowledges every coin after ack_dly WAIT_ACK cycles.
   task automatic applyStimulus(input int amt, input int ack_dly, input bit refill_ack);
      int guard;
      fired.delete();
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) failNow("req_ready_wait");
      req_valid = 1'b1;
      req_amt   = 4'(amt);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!done && lat < 400) begin
         if (hop_fire) begin
            fired.push_back(hop_sel);
            repeat (ack_dly) begin
               @(negedge clk);
               lat++;
            end
            hop_ack    = 1'b1;
            refill_dim = refill_ack;
            @(negedge clk);
            lat++;
            hop_ack    = 1'b0;
            refill_dim = 1'b0;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!done) failNow("done_wait");
   endtask

   task automatic pulseRefill(input bit nck, input bit dim);
      refill_nck = nck;
      refill_dim = dim;
      @(negedge clk);
      refill_nck = 1'b0;
      refill_dim = 1'b0;
   endtask

   initial begin
      int guard;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_amt    = '0;
      hop_ack    = 1'b0;
      refill_nck = 1'b0;
      refill_dim = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);

      // Reset values
      checkOutput("rst_req_ready", int'(req_ready), 1);
      checkOutput("rst_hop_fire", int'(hop_fire), 0);
      checkOutput("rst_hop_sel", int'(hop_sel), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_short", int'(short_amt), 0);
      checkOutput("rst_fault", int'(fault), 0);
      checkOutput("rst_nck", int'(nck_cnt), 20);
      checkOutput("rst_dim", int'(dim_cnt), 10);
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // amt=3 on full tubes: dime then nickel
      applyStimulus(3, 1, 1'b0);
      checkOutput("a3_fires", fired.size(), 2);
      if (fired.size() == 2) begin
         checkOutput("a3_first_dime", int'(fired[0]), 1);
         checkOutput("a3_second_nck", int'(fired[1]), 0);
      end
      checkOutput("a3_short", int'(short_amt), 0);
      checkOutput("a3_nck", int'(nck_cnt), 19);
      checkOutput("a3_dim", int'(dim_cnt), 9);

      // Dime refill in the same cycle as the dime ack
      applyStimulus(2, 2, 1'b1);
      checkOutput("refack_fires", fired.size(), 1);
      checkOutput("refack_dim", int'(dim_cnt), 18);
      checkOutput("refack_nck", int'(nck_cnt), 19);

      // Drain dimes: 15 -> 7 dimes + 1 nickel, 14 -> 7 dimes, 8 -> 4 dimes
      applyStimulus(15, 1, 1'b0);
      checkOutput("a15_fires", fired.size(), 8);
      applyStimulus(14, 3, 1'b0);
      applyStimulus(8, 1, 1'b0);
      checkOutput("drain_dim", int'(dim_cnt), 0);
      checkOutput("drain_nck", int'(nck_cnt), 18);

      // amt=2 with no dimes: two nickels
      applyStimulus(2, 1, 1'b0);
      checkOutput("nodim_fires", fired.size(), 2);
      if (fired.size() == 2) begin
         checkOutput("nodim_sel0", int'(fired[0]), 0);
         checkOutput("nodim_sel1", int'(fired[1]), 0);
      end
      checkOutput("nodim_nck", int'(nck_cnt), 16);
      checkOutput("nodim_short", int'(short_amt), 0);

      // Drain nickels and exercise a partial payout
      applyStimulus(15, 1, 1'b0);
      checkOutput("drain_nck15", int'(nck_cnt), 1);
      applyStimulus(3, 1, 1'b0);
      checkOutput("partial_short", int'(short_amt), 2);
      checkOutput("partial_nck", int'(nck_cnt), 0);

      // Both tubes empty: no fire, done two cycles after accept
      applyStimulus(3, 1, 1'b0);
      checkOutput("empty_fires", fired.size(), 0);
      checkOutput("empty_latency", lat, 2);
      checkOutput("empty_short", int'(short_amt), 3);

      // Zero request
      applyStimulus(0, 1, 1'b0);
      checkOutput("zero_latency", lat, 2);
      checkOutput("zero_short", int'(short_amt), 0);

      // Saturating refill and a nickel refill
      @(negedge clk);
      repeat (26) pulseRefill(1'b0, 1'b1);
      pulseRefill(1'b1, 1'b0);
      checkOutput("sat_dim", int'(dim_cnt), 255);
      checkOutput("refill_nck", int'(nck_cnt), 10);

      // Ack while idle is ignored
      hop_ack = 1'b1;
      @(negedge clk);
      hop_ack = 1'b0;
      @(negedge clk);
      checkOutput("idle_ack_nck", int'(nck_cnt), 10);
      checkOutput("idle_ack_dim", int'(dim_cnt), 255);

      // Reset while waiting for a dime ack
      req_valid = 1'b1;
      req_amt   = 4'd2;
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!hop_fire && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!hop_fire) failNow("rst_fire_wait");
      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("wrst_req_ready", int'(req_ready), 1);
      checkOutput("wrst_hop_fire", int'(hop_fire), 0);
      checkOutput("wrst_hop_sel", int'(hop_sel), 0);
      checkOutput("wrst_done", int'(done), 0);
      checkOutput("wrst_short", int'(short_amt), 0);
      checkOutput("wrst_fault", int'(fault), 0);
      checkOutput("wrst_nck", int'(nck_cnt), 20);
      checkOutput("wrst_dim", int'(dim_cnt), 10);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      @(negedge clk);
      chk_en = 1'b1;
      applyStimulus(1, 1, 1'b0);
      checkOutput("post_rst_nck", int'(nck_cnt), 19);

`ifdef CHANGE_DISP_TIMEOUT_EN
      // Hopper never acks: fault after ACK_TMO WAIT_ACK cycles
      @(negedge clk);
      chk_en    = 1'b0;
      req_valid = 1'b1;
      req_amt   = 4'd1;
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!hop_fire && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!hop_fire) failNow("tmo_fire_wait");
      guard = 0;
      while (!fault && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("tmo_cycles", guard, 16);
      checkOutput("tmo_fault", int'(fault), 1);
      checkOutput("tmo_req_ready", int'(req_ready), 0);
      checkOutput("tmo_short", int'(short_amt), 1);
      checkOutput("tmo_nck", int'(nck_cnt), 19);
      repeat (3) @(negedge clk);
      checkOutput("tmo_sticky", int'(fault), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("tmo_clear_fault", int'(fault), 0);
      checkOutput("tmo_clear_ready", int'(req_ready), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
